// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator for the HDMI output path.
// Free-running h/v counters address the frame buffer. The returned 1-bit
// pixel is re-aligned with delayed sync/DE and mapped to RGB888 through
// CPU-programmable foreground/background colour registers.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIX_LAT  = 1   // frame buffer read latency, 1..4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] xpos_o,
  output logic [11:0] ypos_o,
  input  logic        color_i,
  input  logic        cfg_we_i,
  input  logic        cfg_addr_i,
  input  logic [23:0] cfg_wdata_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [23:0] rgb_o,
  output logic        frame_start_o,
  output logic        line_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS_C   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE_C   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST_C = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS_C   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE_C   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
    logic ls;
  } stage_t;

  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  stage_t      st0;
  stage_t [PIX_LAT-1:0] pipe_q;
  stage_t      al;

  logic [23:0] fg_q, bg_q;
  logic [23:0] rgb_q;
  logic        de_q, hs_q, vs_q, fs_q, ls_q;

  // Next raster position: hcnt wraps every line, vcnt advances on that wrap.
  always_comb begin
    hcnt_d = hcnt_q + 12'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST_C) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST_C) ? 12'd0 : vcnt_q + 12'd1;
    end
  end

  // Raster position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Stage-0 timing flags decoded straight from the counters.
  always_comb begin
    st0     = '0;
    st0.act = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    st0.hs  = (hcnt_q >= H_SS_C) && (hcnt_q < H_SE_C);
    st0.vs  = (vcnt_q >= V_SS_C) && (vcnt_q < V_SE_C);
    st0.fs  = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
    st0.ls  = (hcnt_q == 12'd0) && (vcnt_q < V_ACT_C);
  end

  // Blanking addresses are parked at 0 so the frame buffer never sees an
  // out-of-range coordinate.
  assign xpos_o = st0.act ? hcnt_q : 12'd0;
  assign ypos_o = st0.act ? vcnt_q : 12'd0;

  // Delay line matching the frame buffer read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= st0;
      for (int i = 1; i < PIX_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Flags aligned with the pixel bit currently on color_i.
  assign al = pipe_q[PIX_LAT-1];

  // Colour registers; reset takes priority and drops a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      fg_q <= 24'hFF_FFFF;
      bg_q <= 24'h00_0000;
    end else if (cfg_we_i) begin
      if (cfg_addr_i) fg_q <= cfg_wdata_i;
      else            bg_q <= cfg_wdata_i;
    end
  end

  // Output register: every output moves on the same edge for a given position.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q  <= 1'b0;
      rgb_q <= '0;
      hs_q  <= ~HS_ACT;
      vs_q  <= ~VS_ACT;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
    end else begin
      de_q  <= al.act;
      rgb_q <= al.act ? (color_i ? fg_q : bg_q) : 24'h0;
      hs_q  <= al.hs ? HS_ACT : ~HS_ACT;
      vs_q  <= al.vs ? VS_ACT : ~VS_ACT;
      fs_q  <= al.fs;
      ls_q  <= al.ls;
    end
  end

  assign de_o          = de_q;
  assign rgb_o         = rgb_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign frame_start_o = fs_q;
  assign line_start_o  = ls_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: three instances share clock, reset and config bus.
// u0/u1 use a reduced 15x8 raster (8x4 active) with PIX_LAT 1 and 3; u2 uses
// the full 640x480 timing for first-line checks. Each has a frame buffer
// model returning color = xpos[0] after its read latency.
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic        cfg_addr = 1'b0;
  logic [23:0] cfg_wdata = '0;
  logic        ovr = 1'b0;

  logic [11:0] xp [3];
  logic [11:0] yp [3];
  logic        col [3];
  logic        hs [3];
  logic        vs [3];
  logic        de [3];
  logic        fs [3];
  logic        ls [3];
  logic [23:0] rgb [3];

  logic        fb1 = 1'b0;
  logic        fbd = 1'b0;
  logic [2:0]  fb3 = 3'b000;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Cycle index: 0 is the cycle right after the last edge that saw rst.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Frame buffer models.
  always @(posedge clk) begin
    fb1 <= xp[0][0];
    fb3 <= {fb3[1:0], xp[1][0]};
    fbd <= xp[2][0];
  end
  assign col[0] = ovr | fb1;
  assign col[1] = ovr | fb3[2];
  assign col[2] = ovr | fbd;

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .PIX_LAT(1)) u0 (
    .clk(clk), .rst(rst), .xpos_o(xp[0]), .ypos_o(yp[0]), .color_i(col[0]),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .hsync_o(hs[0]), .vsync_o(vs[0]), .de_o(de[0]), .rgb_o(rgb[0]),
    .frame_start_o(fs[0]), .line_start_o(ls[0]));

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .PIX_LAT(3)) u1 (
    .clk(clk), .rst(rst), .xpos_o(xp[1]), .ypos_o(yp[1]), .color_i(col[1]),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .hsync_o(hs[1]), .vsync_o(vs[1]), .de_o(de[1]), .rgb_o(rgb[1]),
    .frame_start_o(fs[1]), .line_start_o(ls[1]));

  video_timing_gen u2 (
    .clk(clk), .rst(rst), .xpos_o(xp[2]), .ypos_o(yp[2]), .color_i(col[2]),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .hsync_o(hs[2]), .vsync_o(vs[2]), .de_o(de[2]), .rgb_o(rgb[2]),
    .frame_start_o(fs[2]), .line_start_o(ls[2]));

  localparam int NCAP = 1000;
  logic        de_h [3][NCAP];
  logic        hs_h [3][NCAP];
  logic        vs_h [3][NCAP];
  logic        fs_h [3][NCAP];
  logic        ls_h [3][NCAP];
  logic [23:0] rgb_h [3][NCAP];
  logic [11:0] x_h [3][NCAP];
  logic [11:0] y_h [3][NCAP];

  typedef struct {
    int          c;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        ls;
    logic [23:0] rgb;
    logic [11:0] x;
    logic [11:0] y;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int c, input logic d, input logic h, input logic v,
                              input logic f, input logic l, input logic [23:0] r,
                              input logic [11:0] x, input logic [11:0] y);
    vec_t t;
    t.c = c; t.de = d; t.hs = h; t.vs = v; t.fs = f; t.ls = l;
    t.rgb = r; t.x = x; t.y = y;
    return t;
  endfunction

  task automatic chk(input string nm, input int at, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0d: got %0h expected %0h", nm, at, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cfg_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to(input int c);
    int g;
    g = 0;
    while (cyc != c && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("run_to cycle", c, cyc, c);
  endtask

  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        de_h[d][c] = de[d]; hs_h[d][c] = hs[d]; vs_h[d][c] = vs[d];
        fs_h[d][c] = fs[d]; ls_h[d][c] = ls[d]; rgb_h[d][c] = rgb[d];
        x_h[d][c] = xp[d]; y_h[d][c] = yp[d];
      end
    end
  endtask

  // Frame-level properties of a reduced-raster instance.
  task automatic analyze(input int d, input int fs_first);
    int fsl[$];
    int dec, hsl, vsl, lsc, run, maxrun, rises, vfirst, hfirst, w0;
    for (int c = 0; c < 370; c++) if (fs_h[d][c]) fsl.push_back(c);
    chk($sformatf("u%0d frame_start count", d), d, fsl.size(), 4);
    if (fsl.size() >= 2) begin
      chk($sformatf("u%0d first frame_start", d), d, fsl[0], fs_first);
      for (int i = 1; i < fsl.size(); i++)
        chk($sformatf("u%0d frame period", d), fsl[i], fsl[i] - fsl[i-1], 120);
      w0 = fsl[0];
      dec = 0; hsl = 0; vsl = 0; lsc = 0; run = 0; maxrun = 0; rises = 0;
      vfirst = -1; hfirst = -1;
      for (int c = w0; c < w0 + 120; c++) begin
        if (de_h[d][c]) begin
          dec++; run++;
          if (run > maxrun) maxrun = run;
          if (!de_h[d][c-1]) rises++;
        end else run = 0;
        if (!hs_h[d][c]) begin hsl++; if (hfirst < 0) hfirst = c; end
        if (!vs_h[d][c]) begin vsl++; if (vfirst < 0) vfirst = c; end
        if (ls_h[d][c]) lsc++;
      end
      chk($sformatf("u%0d de cycles/frame", d), w0, dec, 32);
      chk($sformatf("u%0d de lines/frame", d), w0, rises, 4);
      chk($sformatf("u%0d de run length", d), w0, maxrun, 8);
      chk($sformatf("u%0d line_start/frame", d), w0, lsc, 4);
      chk($sformatf("u%0d hsync low/frame", d), w0, hsl, 24);
      chk($sformatf("u%0d vsync low/frame", d), w0, vsl, 30);
      chk($sformatf("u%0d hsync start", d), w0, hfirst - w0, 10);
      chk($sformatf("u%0d vsync start", d), w0, vfirst - w0, 75);
    end
  endtask

  initial begin
    vec_t v;
    int o, cnt, first, second;

    //                c    de hs vs fs ls rgb          x      y
    tbl.push_back(mk(0,   0, 1, 1, 0, 0, 24'h000000, 12'd0, 12'd0));
    tbl.push_back(mk(1,   0, 1, 1, 0, 0, 24'h000000, 12'd1, 12'd0));
    tbl.push_back(mk(2,   1, 1, 1, 1, 1, 24'h000000, 12'd2, 12'd0));
    tbl.push_back(mk(3,   1, 1, 1, 0, 0, 24'hFFFFFF, 12'd3, 12'd0));
    tbl.push_back(mk(9,   1, 1, 1, 0, 0, 24'hFFFFFF, 12'd0, 12'd0));
    tbl.push_back(mk(10,  0, 1, 1, 0, 0, 24'h000000, 12'd0, 12'd0));
    tbl.push_back(mk(11,  0, 1, 1, 0, 0, 24'h000000, 12'd0, 12'd0));
    tbl.push_back(mk(12,  0, 0, 1, 0, 0, 24'h000000, 12'd0, 12'd0));
    tbl.push_back(mk(14,  0, 0, 1, 0, 0, 24'h000000, 12'd0, 12'd0));
    tbl.push_back(mk(15,  0, 1, 1, 0, 0, 24'h000000, 12'd0, 12'd1));
    tbl.push_back(mk(16,  0, 1, 1, 0, 0, 24'h000000, 12'd1, 12'd1));
    tbl.push_back(mk(17,  1, 1, 1, 0, 1, 24'h000000, 12'd2, 12'd1));
    tbl.push_back(mk(18,  1, 1, 1, 0, 0, 24'hFFFFFF, 12'd3, 12'd1));
    tbl.push_back(mk(47,  1, 1, 1, 0, 1, 24'h000000, 12'd2, 12'd3));
    tbl.push_back(mk(54,  1, 1, 1, 0, 0, 24'hFFFFFF, 12'd0, 12'd0));
    tbl.push_back(mk(62,  0, 1, 1, 0, 0, 24'h000000, 12'd0, 12'd0));
    tbl.push_back(mk(76,  0, 1, 1, 0, 0, 24'h000000, 12'd0, 12'd0));
    tbl.push_back(mk(77,  0, 1, 0, 0, 0, 24'h000000, 12'd0, 12'd0));
    tbl.push_back(mk(87,  0, 0, 0, 0, 0, 24'h000000, 12'd0, 12'd0));
    tbl.push_back(mk(106, 0, 1, 0, 0, 0, 24'h000000, 12'd0, 12'd0));
    tbl.push_back(mk(107, 0, 1, 1, 0, 0, 24'h000000, 12'd0, 12'd0));
    tbl.push_back(mk(121, 0, 1, 1, 0, 0, 24'h000000, 12'd1, 12'd0));
    tbl.push_back(mk(122, 1, 1, 1, 1, 1, 24'h000000, 12'd2, 12'd0));

    // Free run from reset, then compare recorded waveforms.
    reset_dut();
    capture(NCAP);

    // u1 (PIX_LAT=3) must show u0's pattern exactly 2 clocks later.
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      for (int d = 0; d < 2; d++) begin
        o = v.c + 2 * d;
        chk($sformatf("u%0d de", d), o, de_h[d][o], v.de);
        chk($sformatf("u%0d hsync", d), o, hs_h[d][o], v.hs);
        chk($sformatf("u%0d vsync", d), o, vs_h[d][o], v.vs);
        chk($sformatf("u%0d frame_start", d), o, fs_h[d][o], v.fs);
        chk($sformatf("u%0d line_start", d), o, ls_h[d][o], v.ls);
        chk($sformatf("u%0d rgb", d), o, rgb_h[d][o], v.rgb);
        chk($sformatf("u%0d xpos", d), v.c, x_h[d][v.c], v.x);
        chk($sformatf("u%0d ypos", d), v.c, y_h[d][v.c], v.y);
      end
    end

    analyze(0, 2);
    analyze(1, 4);

    // Full-size timing, first line.
    chk("u2 frame_start", 2, fs_h[2][2], 1);
    chk("u2 de first", 2, de_h[2][2], 1);
    chk("u2 de last", 641, de_h[2][641], 1);
    cnt = 0;
    for (int c = 0; c < 643; c++) if (de_h[2][c]) cnt++;
    chk("u2 de run", 0, cnt, 640);
    cnt = 0; first = -1;
    for (int c = 0; c < NCAP; c++) if (!hs_h[2][c]) begin cnt++; if (first < 0) first = c; end
    chk("u2 hsync low width", 0, cnt, 96);
    chk("u2 hsync start", 0, first, 658);
    cnt = 0; first = -1; second = -1;
    for (int c = 0; c < NCAP; c++) if (ls_h[2][c]) begin
      cnt++;
      if (first < 0) first = c; else second = c;
    end
    chk("u2 line_start count", 0, cnt, 2);
    chk("u2 line period", 0, second - first, 800);
    cnt = 0;
    for (int c = 0; c < NCAP; c++) if (!vs_h[2][c]) cnt++;
    chk("u2 vsync low in line 0-1", 0, cnt, 0);
    chk("u2 rgb pixel0", 2, rgb_h[2][2], 24'h000000);
    chk("u2 rgb pixel1", 3, rgb_h[2][3], 24'hFFFFFF);

    // Colour writes during vertical blanking, visible next frame.
    reset_dut();
    run_to(64);
    cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 24'h00FF00;
    @(negedge clk);
    cfg_addr = 1'b0; cfg_wdata = 24'h200040;
    @(negedge clk);
    cfg_we = 1'b0;
    run_to(122); chk("u0 bg next frame", 122, rgb[0], 24'h200040);
    run_to(123); chk("u0 fg next frame", 123, rgb[0], 24'h00FF00);
    run_to(124); chk("u0 bg pixel2", 124, rgb[0], 24'h200040);
                 chk("u1 bg next frame", 124, rgb[1], 24'h200040);
    run_to(125); chk("u1 fg next frame", 125, rgb[1], 24'h00FF00);
    run_to(130); chk("u0 blank rgb", 130, rgb[0], 24'h000000);

    // Mid-line write with color forced high.
    reset_dut();
    ovr = 1'b1;
    run_to(12); chk("u0 color ignored in blank", 12, rgb[0], 24'h000000);
    run_to(18); chk("u0 fg before write", 18, rgb[0], 24'hFFFFFF);
    run_to(19);
    cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 24'h123456;
    run_to(20);
    cfg_we = 1'b0;
    chk("u0 fg write edge", 20, rgb[0], 24'hFFFFFF);
    chk("u1 fg write edge", 20, rgb[1], 24'hFFFFFF);
    run_to(21);
    chk("u0 fg after write", 21, rgb[0], 24'h123456);
    chk("u1 fg after write", 21, rgb[1], 24'h123456);
    ovr = 1'b0;

    // Mid-frame reset with a coincident colour write.
    reset_dut();
    run_to(35);
    chk("u0 de before reset", 35, de[0], 1);
    chk("u0 xpos before reset", 35, xp[0], 5);
    chk("u0 ypos before reset", 35, yp[0], 2);
    rst = 1'b1; cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 24'h0000AA;
    @(negedge clk);
    chk("u0 de in reset", 36, de[0], 0);
    chk("u0 rgb in reset", 36, rgb[0], 24'h0);
    chk("u0 hsync in reset", 36, hs[0], 1);
    chk("u0 vsync in reset", 36, vs[0], 1);
    chk("u0 xpos in reset", 36, xp[0], 0);
    chk("u0 ypos in reset", 36, yp[0], 0);
    chk("u1 de in reset", 36, de[1], 0);
    rst = 1'b0; cfg_we = 1'b0;
    run_to(1); chk("u0 no early frame_start", 1, fs[0], 0);
    run_to(2); chk("u0 frame_start after reset", 2, fs[0], 1);
    run_to(3); chk("u0 fg survives reset write", 3, rgb[0], 24'hFFFFFF);
               chk("u1 no early frame_start", 3, fs[1], 0);
    run_to(4); chk("u1 frame_start after reset", 4, fs[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates 640x480@60 raster timing for the HDMI output path.
- Drives xpos/ypos into the frame buffer pixel port and takes the returned 1-bit pixel back.
- Aligns the returned pixel with delayed sync and data-enable, then maps it to 24-bit RGB through CPU-programmable foreground/background colour registers.
- Sits between the frame buffer and the TMDS encoder.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
PIX_LAT, 1, clocks from xpos/ypos change to valid color input (range 1..4)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
xpos  out  12  pixel column to frame buffer
ypos  out  12  pixel row to frame buffer
color  in  1  pixel bit returned by frame buffer
cfg_we  in  1  colour register write strobe
cfg_addr  in  1  0 = background, 1 = foreground
cfg_wdata  in  24  RGB888 value to write
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  data enable, high during active pixels
rgb  out  24  pixel colour, {R,G,B}
frame_start  out  1  one-clock pulse aligned with first active pixel of a frame
line_start  out  1  one-clock pulse aligned with first active pixel of each active line

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL analogous (525).
- Counters:
  - hcnt counts 0..H_TOTAL-1 every clock.
  - On wrap, hcnt returns to 0 and vcnt increments; vcnt wraps V_TOTAL-1 to 0.
- Stage-0 signals, combinational from the counters:
  - act0 = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - hs0 = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs0 = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), whole lines.
  - fs0 = hcnt==0 && vcnt==0.
  - ls0 = hcnt==0 && vcnt<V_ACTIVE.
- Address outputs:
  - xpos = act0 ? hcnt : 0; ypos = act0 ? vcnt : 0.
  - Blanking addresses stay inside the frame buffer range.
- Alignment pipe: act0/hs0/vs0/fs0/ls0 pass through a PIX_LAT-deep shift register, sampled together with color, then one output register stage.
  - Total latency from counter value to hsync/vsync/de/rgb outputs is PIX_LAT+1 clocks.
  - For any counter position, all outputs change on the same edge.
- Output mapping:
  - rgb = de_pipe ? (color ? fg : bg) : 24'h0.
  - hsync = hs_pipe ? HS_POL : ~HS_POL; vsync likewise with VS_POL.
- Colour registers:
  - Written on the clock where cfg_we=1: cfg_addr 0 writes bg, 1 writes fg.
  - The new value affects rgb from the next output register update.
  - Mid-line writes are permitted; a colour change within a line is accepted.
- Reset, synchronous, applies to all state:
  - hcnt=vcnt=0, pipe cleared to inactive.
  - fg=24'hFFFFFF, bg=24'h000000.
  - de=0, rgb=0, hsync=~HS_POL, vsync=~VS_POL, frame_start=0, line_start=0.
  - xpos=ypos=0.
  - A reset asserted mid-frame restarts the frame; the first frame_start appears PIX_LAT+1 clocks after rst deasserts.
- Simultaneous cfg_we and rst: rst wins, and the write is dropped.
- color is ignored whenever the aligned de is 0.

Test Plan:
- Reset, run 2 frames -> frame_start pulses exactly 420000 clocks apart; de high for 640 consecutive clocks on each of 480 lines per frame; 307200 de-cycles per frame.
- Sync timing -> hsync low for 96 clocks, starting 656 clocks after de rises at line start; vsync low for 2 full lines (1600 clocks) starting at line 490; both high at all other times.
- Frame buffer model with PIX_LAT=1 returning color = xpos[0] -> rgb alternates FFFFFF/000000 within active pixels, first pixel of each line is 000000, rgb=0 in blanking. Repeat with PIX_LAT=3 -> identical output pattern, shifted 2 clocks later.
- Write cfg_addr=1 value 24'h00FF00 and cfg_addr=0 value 24'h200040 during blanking -> next frame shows 00FF00 for set pixels and 200040 for clear pixels. Write during active video -> change appears exactly 1 output clock after the write.
- Assert rst at hcnt=300, vcnt=200 for 1 clock -> outputs return to reset values next clock; xpos=ypos=0; frame_start fires PIX_LAT+1 clocks after release; cfg_we asserted together with rst has no effect (fg reads back as FFFFFF).
